// File: rtl/seq_detector.sv
`default_nettype none
// ============================================================================
//  Module   : seq_detector
//  Purpose  : Code-lock style detector. Collects single-bit symbols from two
//             pulse inputs, compares the completed entry against SEQUENCE,
//             and reports match/fail pulses plus an unlocked level.
//  Revision : 1.0  initial release
// ============================================================================
module seq_detector #(
  parameter int                 SEQ_LEN       = 4,
  parameter logic [SEQ_LEN-1:0] SEQUENCE      = 4'b1011,
  parameter int                 TIMEOUT_WIDTH = 24
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       sym0,
  input  logic       sym1,
  input  logic       clr,
  output logic       match,
  output logic       fail,
  output logic       unlocked,
  output logic [3:0] count
);

  // State encoding; the three spare codes fall into the default recovery arm
  localparam logic [2:0] c_IDLE    = 3'd0;
  localparam logic [2:0] c_COLLECT = 3'd1;
  localparam logic [2:0] c_CHECK   = 3'd2;
  localparam logic [2:0] c_FAIL    = 3'd3;
  localparam logic [2:0] c_OPEN    = 3'd4;

  localparam logic [3:0]               c_SEQ_LEN   = 4'(SEQ_LEN);
  localparam logic [TIMEOUT_WIDTH-1:0] c_TIMER_ONE = TIMEOUT_WIDTH'(1);

  logic [2:0]               r_state;
  logic [SEQ_LEN-1:0]       r_shreg;
  logic [3:0]               r_count;
  logic [TIMEOUT_WIDTH-1:0] r_timer;

  logic                     w_valid;
  logic [SEQ_LEN-1:0]       w_shift;
  logic [3:0]               w_cnt_inc;
  logic                     w_last;

  // Both buttons at once is ambiguous and is treated as no symbol
  assign w_valid   = sym0 ^ sym1;
  assign w_cnt_inc = r_count + 4'd1;
  assign w_last    = (w_cnt_inc == c_SEQ_LEN);

  // New symbol enters at the LSB so the first symbol ends up at the MSB
  generate
    if (SEQ_LEN == 1) begin : g_shift_one
      assign w_shift = sym1;
    end else begin : g_shift_wide
      assign w_shift = {r_shreg[SEQ_LEN-2:0], sym1};
    end
  endgenerate

  // State machine with shift register, symbol counter and idle timer
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= c_IDLE;
      r_shreg <= '0;
      r_count <= '0;
      r_timer <= '0;
    end else begin
      case (r_state)
        c_IDLE: begin
          r_timer <= '0;
          if (w_valid) begin
            r_shreg <= w_shift;
            r_count <= w_cnt_inc;
            r_state <= w_last ? c_CHECK : c_COLLECT;
          end else begin
            r_shreg <= '0;
            r_count <= '0;
          end
        end
        c_COLLECT: begin
          if (clr) begin
            r_state <= c_IDLE;
            r_shreg <= '0;
            r_count <= '0;
            r_timer <= '0;
          end else if (w_valid) begin
            r_shreg <= w_shift;
            r_count <= w_cnt_inc;
            r_timer <= '0;
            r_state <= w_last ? c_CHECK : c_COLLECT;
          end else if (&r_timer) begin
            r_state <= c_FAIL;
            r_shreg <= '0;
            r_count <= '0;
            r_timer <= '0;
          end else begin
            r_timer <= r_timer + c_TIMER_ONE;
          end
        end
        c_CHECK: begin
          // Verdict is taken from the register this cycle; progress is dropped
          r_state <= (r_shreg == SEQUENCE) ? c_OPEN : c_FAIL;
          r_shreg <= '0;
          r_count <= '0;
          r_timer <= '0;
        end
        c_FAIL: begin
          r_state <= c_IDLE;
        end
        c_OPEN: begin
          if (clr) begin
            r_state <= c_IDLE;
          end
        end
        default: begin
          r_state <= c_IDLE;
          r_shreg <= '0;
          r_count <= '0;
          r_timer <= '0;
        end
      endcase
    end
  end

  // Outputs come only from registered state and counters
  assign match    = (r_state == c_CHECK) && (r_shreg == SEQUENCE);
  assign fail     = (r_state == c_FAIL);
  assign unlocked = (r_state == c_OPEN);
  assign count    = r_count;

endmodule
`default_nettype wire

// File: tb/tb_seq_detector.sv
`default_nettype none
// ============================================================================
//  Module   : tb_seq_detector
//  Purpose  : Self-checking bench for seq_detector with directed scenarios
//             followed by random stimulus against a behavioural model.
//  Revision : 1.0  initial release
// ============================================================================
module tb_seq_detector;

  localparam int         LEN = 4;
  localparam logic [3:0] SEQ = 4'b1011;
  localparam int         TW  = 4;
  localparam int         IDLE_LIMIT = 1 << TW;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       sym0 = 1'b0;
  logic       sym1 = 1'b0;
  logic       clr = 1'b0;
  logic       match;
  logic       fail;
  logic       unlocked;
  logic [3:0] count;

  int n_total = 0;
  int n_bad   = 0;

  // Reference model: collected symbols plus scheduled verdict/timeout cycles
  bit q[$];
  int cyc         = 0;
  int idle        = 0;
  bit open        = 0;
  int verdict_cyc = -10;
  bit verdict_ok  = 0;
  int tfail_cyc   = -10;

  seq_detector #(
    .SEQ_LEN       (LEN),
    .SEQUENCE      (SEQ),
    .TIMEOUT_WIDTH (TW)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .sym0     (sym0),
    .sym1     (sym1),
    .clr      (clr),
    .match    (match),
    .fail     (fail),
    .unlocked (unlocked),
    .count    (count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int got, input int exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s cycle=%0d got=%0d expected=%0d", tag, cyc, got, exp);
    end
  endtask

  function automatic int pack_entry();
    int v = 0;
    foreach (q[i]) v = (v << 1) | int'(q[i]);
    return v;
  endfunction

  // Advance the model by one clock using the inputs sampled at this edge
  task automatic model_step(input bit s0, input bit s1, input bit c, input bit r);
    bit v = s0 ^ s1;
    int prev = cyc;
    cyc++;
    if (r) begin
      q.delete();
      idle = 0;
      open = 0;
      verdict_cyc = -10;
      tfail_cyc = -10;
    end else if (open) begin
      if (c) open = 0;
    end else if (prev == verdict_cyc) begin
      if (verdict_ok) open = 1;
    end else if ((prev == verdict_cyc + 1) || (prev == tfail_cyc)) begin
      // fail cycle: inputs are dropped
    end else begin
      if (c && q.size() > 0) begin
        q.delete();
        idle = 0;
      end else if (v) begin
        q.push_back(s1);
        idle = 0;
        if (q.size() == LEN) begin
          verdict_cyc = cyc;
          verdict_ok  = (pack_entry() == int'(SEQ));
          q.delete();
        end
      end else if (q.size() > 0) begin
        idle++;
        if (idle == IDLE_LIMIT) begin
          tfail_cyc = cyc;
          q.delete();
          idle = 0;
        end
      end
    end
  endtask

  task automatic compare_outputs();
    int e_match = ((cyc == verdict_cyc) && verdict_ok) ? 1 : 0;
    int e_fail  = (((cyc == verdict_cyc + 1) && !verdict_ok) || (cyc == tfail_cyc)) ? 1 : 0;
    int e_count = (cyc == verdict_cyc) ? LEN : q.size();
    check("match",    int'(match),    e_match);
    check("fail",     int'(fail),     e_fail);
    check("unlocked", int'(unlocked), int'(open));
    check("count",    int'(count),    e_count);
  endtask

  // One clock: drive inputs, let the edge happen, then compare
  task automatic step(input bit s0, input bit s1, input bit c, input bit r);
    sym0 = s0;
    sym1 = s1;
    clr  = c;
    rst  = r;
    @(posedge clk);
    model_step(s0, s1, c, r);
    #1;
    compare_outputs();
  endtask

  task automatic send(input bit b, input int gap);
    step(!b, b, 1'b0, 1'b0);
    repeat (gap) step(1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic idle_for(input int n);
    repeat (n) step(1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    bit b;
    int pick;
    // Reset and quiescent state
    repeat (3) step(1'b0, 1'b0, 1'b0, 1'b1);
    idle_for(2);

    // Correct entry with spaced pulses, then relock
    send(1, 2); send(0, 2); send(1, 2); send(1, 0);
    idle_for(4);
    step(1'b0, 1'b0, 1'b1, 1'b0);
    idle_for(2);

    // Wrong entry
    send(1, 2); send(0, 2); send(0, 2); send(1, 0);
    idle_for(4);

    // Timeout after two symbols
    send(1, 1); send(0, 0);
    idle_for(20);

    // Simultaneous buttons ignored mid-entry
    send(1, 0); send(0, 0);
    step(1'b1, 1'b1, 1'b0, 1'b0);
    send(1, 0); send(1, 0);
    idle_for(3);
    step(1'b0, 1'b0, 1'b1, 1'b0);

    // Clear wins over a same-cycle symbol, then a fresh entry
    send(1, 0); send(0, 0);
    step(1'b0, 1'b1, 1'b1, 1'b0);
    idle_for(2);
    send(1, 0); send(0, 0); send(1, 0); send(1, 0);
    idle_for(2);
    step(1'b0, 1'b0, 1'b1, 1'b0);

    // Reset mid-entry, then a 5-symbol burst with the 5th during check
    send(1, 0); send(0, 0); send(1, 0);
    step(1'b0, 1'b0, 1'b0, 1'b1);
    idle_for(2);
    send(1, 0); send(0, 0); send(1, 0); send(1, 0); send(0, 0);
    idle_for(3);
    step(1'b0, 1'b0, 1'b0, 1'b1);
    idle_for(2);

    // Random traffic, half the symbols steered toward the target sequence
    for (int i = 0; i < 3000; i++) begin
      pick = int'($urandom_range(0, 99));
      if (pick < 2) begin
        step(1'b0, 1'b0, 1'b0, 1'b1);
      end else if (pick < 8) begin
        step($urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1, 1'b1, 1'b0);
      end else if (pick < 24) begin
        if ($urandom_range(0, 1) == 1 && q.size() < LEN)
          b = SEQ[LEN-1-q.size()];
        else
          b = $urandom_range(0, 1) == 1;
        step(!b, b, 1'b0, 1'b0);
      end else if (pick < 27) begin
        step(1'b1, 1'b1, 1'b0, 1'b0);
      end else begin
        step(1'b0, 1'b0, 1'b0, 1'b0);
      end
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
